// File: rtl/srcmac_arb_pkg.sv
// Shared definitions for the source-MAC learn arbiter and its helpers.
package srcmac_arb_pkg;

  localparam int DEFAULT_MACW = 48;
  localparam int MAX_NPORTS   = 16;
  localparam int MAX_LGPORTS  = $clog2(MAX_NPORTS);

  // One learn record as presented to the routing table
  typedef struct packed {
    logic [MAX_LGPORTS-1:0]  port;
    logic [DEFAULT_MACW-1:0] mac;
  } learn_rec_t;

  // Round-robin successor of idx within 0..n-1
  function automatic int rrNext(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/srcmac_learn_arb_rr_pick.sv
// Combinational round-robin picker: scans requests starting at ptr_i,
// wrapping modulo N, and returns the first requester found.
module rr_pick #(
  parameter int N   = 4,
  parameter int LGN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [LGN-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [LGN-1:0] index_o,
  output logic           any_o
);

  // Rotate-and-priority-encode: first requester at or after the pointer wins
  always_comb begin
    int             pos;
    logic [LGN-1:0] idx;
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) pos = pos - N;
      idx = LGN'(pos);
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        index_o      = idx;
      end
    end
  end

endmodule

// File: rtl/srcmac_learn_arb.sv
// Source-MAC learn arbiter: shares one routing-table learn port between
// NPORTS per-interface extractors using round-robin arbitration.
// Optional duplicate suppression is enabled with SRCMAC_ARB_DEDUP_EN.
module srcmac_learn_arb
  import srcmac_arb_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int LGPORTS = $clog2(NPORTS),
  parameter int MACW    = DEFAULT_MACW
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NPORTS-1:0]      S_VALID,
  output logic [NPORTS-1:0]      S_READY,
  input  logic [NPORTS*MACW-1:0] S_SRCMAC,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic [MACW-1:0]        M_SRCMAC,
  output logic [LGPORTS-1:0]     M_PORT,
`ifdef SRCMAC_ARB_DEDUP_EN
  output logic [15:0]            o_dup_count,
`endif
  output logic [15:0]            o_grant_count
);

  logic [MACW-1:0]    srcMac [NPORTS];
  logic [NPORTS-1:0]  grant;
  logic [LGPORTS-1:0] winIdx;
  logic               anyReq;
  logic               slotFree;
  logic               accept;
  logic               load;

  logic               mValidQ, mValidD;
  logic [MACW-1:0]    mSrcMacQ, mSrcMacD;
  logic [LGPORTS-1:0] mPortQ, mPortD;
  logic [LGPORTS-1:0] rrPtrQ, rrPtrD;
  logic [15:0]        grantCntQ, grantCntD;

  for (genvar k = 0; k < NPORTS; k++) begin : gSplit
    assign srcMac[k] = S_SRCMAC[k*MACW +: MACW];
  end

  rr_pick #(
    .N   (NPORTS),
    .LGN (LGPORTS)
  ) uPick (
    .req_i   (S_VALID),
    .ptr_i   (rrPtrQ),
    .grant_o (grant),
    .index_o (winIdx),
    .any_o   (anyReq)
  );

  assign slotFree = !mValidQ || M_READY;
  assign S_READY  = (i_reset_n && slotFree) ? grant : '0;
  assign accept   = i_reset_n && slotFree && anyReq;

`ifdef SRCMAC_ARB_DEDUP_EN
  logic               lastVldQ, lastVldD;
  logic [MACW-1:0]    lastMacQ, lastMacD;
  logic [LGPORTS-1:0] lastPortQ, lastPortD;
  logic [15:0]        dupCntQ, dupCntD;
  logic               isDup;

  assign isDup = lastVldQ && (lastMacQ == srcMac[winIdx]) && (lastPortQ == winIdx);
  assign load  = accept && !isDup;

  // Remember the last loaded entry and count suppressed repeats of it
  always_comb begin
    lastVldD  = lastVldQ;
    lastMacD  = lastMacQ;
    lastPortD = lastPortQ;
    dupCntD   = dupCntQ;
    if (load) begin
      lastVldD  = 1'b1;
      lastMacD  = srcMac[winIdx];
      lastPortD = winIdx;
    end
    if (accept && isDup) dupCntD = dupCntQ + 16'd1;
  end

  // Dedup state registers, cleared by reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lastVldQ  <= 1'b0;
      lastMacQ  <= '0;
      lastPortQ <= '0;
      dupCntQ   <= '0;
    end else begin
      lastVldQ  <= lastVldD;
      lastMacQ  <= lastMacD;
      lastPortQ <= lastPortD;
      dupCntQ   <= dupCntD;
    end
  end

  assign o_dup_count = dupCntQ;
`else
  assign load = accept;
`endif

  // Next state of the output slot, pointer and forwarded-request counter
  always_comb begin
    mValidD   = mValidQ;
    mSrcMacD  = mSrcMacQ;
    mPortD    = mPortQ;
    rrPtrD    = rrPtrQ;
    grantCntD = grantCntQ;
    if (mValidQ && M_READY) grantCntD = grantCntQ + 16'd1;
    if (accept) rrPtrD = LGPORTS'(rrNext(int'(winIdx), NPORTS));
    if (load) begin
      mValidD  = 1'b1;
      mSrcMacD = srcMac[winIdx];
      mPortD   = winIdx;
    end else if (slotFree) begin
      mValidD = 1'b0;
    end
  end

  // Output slot registers; reset discards any pending entry
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      mValidQ   <= 1'b0;
      mSrcMacQ  <= '0;
      mPortQ    <= '0;
      rrPtrQ    <= '0;
      grantCntQ <= '0;
    end else begin
      mValidQ   <= mValidD;
      mSrcMacQ  <= mSrcMacD;
      mPortQ    <= mPortD;
      rrPtrQ    <= rrPtrD;
      grantCntQ <= grantCntD;
    end
  end

  assign M_VALID       = mValidQ;
  assign M_SRCMAC      = mSrcMacQ;
  assign M_PORT        = mPortQ;
  assign o_grant_count = grantCntQ;

endmodule

// File: tb/tb_srcmac_learn_arb.sv
// Directed self-checking bench for srcmac_learn_arb (4-port and 3-port builds).
module tb_srcmac_learn_arb;

  localparam logic [47:0] MACBASE = 48'h00A0_0000_0000;

  logic         clk;
  logic         resetN;
  logic [3:0]   sValid, sReady;
  logic [191:0] sSrcMac;
  logic         mValid, mReady;
  logic [47:0]  mSrcMac;
  logic [1:0]   mPort;
  logic [15:0]  grantCount;

  logic [2:0]   sValid3, sReady3;
  logic [143:0] sSrcMac3;
  logic         mValid3, mReady3;
  logic [47:0]  mSrcMac3;
  logic [1:0]   mPort3;
  logic [15:0]  grantCount3;

`ifdef SRCMAC_ARB_DEDUP_EN
  logic [15:0]  dupCount, dupCount3;
`endif

  int compCount = 0;
  int errCount  = 0;
  int order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};

  srcmac_learn_arb #(.NPORTS(4), .MACW(48)) dut4 (
    .i_clk         (clk),
    .i_reset_n     (resetN),
    .S_VALID       (sValid),
    .S_READY       (sReady),
    .S_SRCMAC      (sSrcMac),
    .M_VALID       (mValid),
    .M_READY       (mReady),
    .M_SRCMAC      (mSrcMac),
    .M_PORT        (mPort),
`ifdef SRCMAC_ARB_DEDUP_EN
    .o_dup_count   (dupCount),
`endif
    .o_grant_count (grantCount)
  );

  srcmac_learn_arb #(.NPORTS(3), .MACW(48)) dut3 (
    .i_clk         (clk),
    .i_reset_n     (resetN),
    .S_VALID       (sValid3),
    .S_READY       (sReady3),
    .S_SRCMAC      (sSrcMac3),
    .M_VALID       (mValid3),
    .M_READY       (mReady3),
    .M_SRCMAC      (mSrcMac3),
    .M_PORT        (mPort3),
`ifdef SRCMAC_ARB_DEDUP_EN
    .o_dup_count   (dupCount3),
`endif
    .o_grant_count (grantCount3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic r);
    sValid = v;
    mReady = r;
  endtask

  task automatic setMac(input int k, input logic [47:0] mac);
    sSrcMac[k*48 +: 48] = mac;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Linear sequence of directed steps
  initial begin
    clk = 1'b0; resetN = 1'b0;
    sValid = '0; sSrcMac = '0; mReady = 1'b0;
    sValid3 = '0; sSrcMac3 = '0; mReady3 = 1'b1;
    for (int k = 0; k < 4; k++) setMac(k, MACBASE + 48'(k));
    tick(); tick();

    // Reset state
    checkOutput("rst_mvalid", 64'(mValid), 64'd0);
    checkOutput("rst_mport", 64'(mPort), 64'd0);
    checkOutput("rst_mmac", 64'(mSrcMac), 64'd0);
    checkOutput("rst_gcount", 64'(grantCount), 64'd0);
    applyStimulus(4'hF, 1'b1); sValid3 = 3'b111; #1;
    checkOutput("rst_sready", 64'(sReady), 64'd0);
    checkOutput("rst_sready3", 64'(sReady3), 64'd0);
    applyStimulus(4'h0, 1'b1); sValid3 = '0; resetN = 1'b1;
    tick();

    // Single request from port 2
    setMac(2, 48'h0200_0000_00AA);
    applyStimulus(4'b0100, 1'b1); #1;
    checkOutput("single_sready", 64'(sReady), 64'b0100);
    tick();
    checkOutput("single_mvalid", 64'(mValid), 64'd1);
    checkOutput("single_mport", 64'(mPort), 64'd2);
    checkOutput("single_mmac", 64'(mSrcMac), 64'h0200_0000_00AA);
    applyStimulus(4'h0, 1'b1);
    tick();
    checkOutput("single_idle", 64'(mValid), 64'd0);
    checkOutput("single_gcount", 64'(grantCount), 64'd1);

    // All ports valid: pointer sits at 3 after the single request
    setMac(2, MACBASE + 48'd2);
    applyStimulus(4'hF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("rr_sready", 64'(sReady), 64'(4'b0001 << order[i]));
      tick();
      checkOutput("rr_mvalid", 64'(mValid), 64'd1);
      checkOutput("rr_mport", 64'(mPort), 64'(order[i]));
      checkOutput("rr_mmac", 64'(mSrcMac), 64'(MACBASE + 48'(order[i])));
    end
    checkOutput("rr_gcount", 64'(grantCount), 64'd8);

    // Backpressure holds the slot and blocks all requesters
    applyStimulus(4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_sready", 64'(sReady), 64'd0);
      tick();
      checkOutput("bp_mvalid", 64'(mValid), 64'd1);
      checkOutput("bp_mport", 64'(mPort), 64'd2);
      checkOutput("bp_mmac", 64'(mSrcMac), 64'(MACBASE + 48'd2));
    end
    checkOutput("bp_gcount", 64'(grantCount), 64'd8);
    applyStimulus(4'hF, 1'b1); #1;
    checkOutput("bp_release_sready", 64'(sReady), 64'b1000);
    tick();
    checkOutput("bp_nobubble_mvalid", 64'(mValid), 64'd1);
    checkOutput("bp_nobubble_mport", 64'(mPort), 64'd3);
    checkOutput("bp_gcount2", 64'(grantCount), 64'd9);
    applyStimulus(4'h0, 1'b1);
    tick();
    checkOutput("bp_drain", 64'(mValid), 64'd0);
    checkOutput("bp_gcount3", 64'(grantCount), 64'd10);

    // Reset while an entry is pending
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("mrst_pending", 64'(mPort), 64'd1);
    resetN = 1'b0;
    applyStimulus(4'hF, 1'b1); #1;
    checkOutput("mrst_sready", 64'(sReady), 64'd0);
    tick();
    checkOutput("mrst_mvalid", 64'(mValid), 64'd0);
    checkOutput("mrst_mport", 64'(mPort), 64'd0);
    checkOutput("mrst_mmac", 64'(mSrcMac), 64'd0);
    checkOutput("mrst_gcount", 64'(grantCount), 64'd0);
    resetN = 1'b1;
    applyStimulus(4'b1010, 1'b1); #1;
    checkOutput("mrst_first_sready", 64'(sReady), 64'b0010);
    tick();
    checkOutput("mrst_first_mport", 64'(mPort), 64'd1);
    applyStimulus(4'h0, 1'b1);
    tick();
    checkOutput("mrst_gcount2", 64'(grantCount), 64'd1);

    // Same MAC twice from port 1, then from port 2
    setMac(1, 48'h11);
    applyStimulus(4'b0010, 1'b1); #1;
    checkOutput("dup_sready1", 64'(sReady), 64'b0010);
    tick();
    checkOutput("dup_mvalid1", 64'(mValid), 64'd1);
    checkOutput("dup_mport1", 64'(mPort), 64'd1);
    checkOutput("dup_mmac1", 64'(mSrcMac), 64'h11);
    #1;
    checkOutput("dup_sready2", 64'(sReady), 64'b0010);
    tick();
`ifdef SRCMAC_ARB_DEDUP_EN
    checkOutput("dup_suppressed", 64'(mValid), 64'd0);
`else
    checkOutput("dup_forwarded", 64'(mValid), 64'd1);
    checkOutput("dup_forwarded_port", 64'(mPort), 64'd1);
`endif
    checkOutput("dup_gcount1", 64'(grantCount), 64'd2);
    setMac(2, 48'h11);
    applyStimulus(4'b0100, 1'b1); #1;
    checkOutput("dup_sready3", 64'(sReady), 64'b0100);
    tick();
    checkOutput("dup_mvalid3", 64'(mValid), 64'd1);
    checkOutput("dup_mport3", 64'(mPort), 64'd2);
    checkOutput("dup_mmac3", 64'(mSrcMac), 64'h11);
    applyStimulus(4'h0, 1'b1);
    tick();
    checkOutput("dup_idle", 64'(mValid), 64'd0);
`ifdef SRCMAC_ARB_DEDUP_EN
    checkOutput("dup_gcount2", 64'(grantCount), 64'd3);
    checkOutput("dup_count", 64'(dupCount), 64'd1);
`else
    checkOutput("dup_gcount2", 64'(grantCount), 64'd4);
`endif

    // Three-port build: pointer wrap with requests on ports 0 and 2
    sSrcMac3 = {48'h0000_0000_0C02, 48'h0000_0000_0C01, 48'h0000_0000_0C00};
    sValid3 = 3'b010; #1;
    checkOutput("p3_sready_a", 64'(sReady3), 64'b010);
    tick();
    checkOutput("p3_mport_a", 64'(mPort3), 64'd1);
    sValid3 = 3'b101; #1;
    checkOutput("p3_sready_b", 64'(sReady3), 64'b100);
    tick();
    checkOutput("p3_mport_b", 64'(mPort3), 64'd2);
    checkOutput("p3_mmac_b", 64'(mSrcMac3), 64'h0C02);
    #1;
    checkOutput("p3_sready_c", 64'(sReady3), 64'b001);
    tick();
    checkOutput("p3_mport_c", 64'(mPort3), 64'd0);
    #1;
    checkOutput("p3_sready_d", 64'(sReady3), 64'b100);
    tick();
    checkOutput("p3_mport_d", 64'(mPort3), 64'd2);
    checkOutput("p3_gcount", 64'(grantCount3), 64'd3);
    sValid3 = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
